// File: rtl/spi_stream_slave.sv
`timescale 1ns/1ps
// spi_stream_slave: CS-framed SPI slave, 4 modes, command capture and valid/ready data streams
module spi_stream_slave #(
  parameter int WORD_W = 8,
  parameter int CMD_WORDS = 6,
  parameter int MAX_WORDS = 64,
  parameter int LEN_W = $clog2(MAX_WORDS),
  parameter logic [WORD_W-1:0] FILL = '1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        sclk,
  input  logic                        cs_n,
  input  logic                        mosi,
  output logic                        miso,
  input  logic [1:0]                  mode,
  output logic [CMD_WORDS*WORD_W-1:0] cmd,
  output logic                        cmd_valid,
  input  logic                        start,
  input  logic                        op,
  input  logic [LEN_W-1:0]            len,
  output logic [WORD_W-1:0]           rx_data,
  output logic                        rx_valid,
  input  logic [WORD_W-1:0]           tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic                        busy,
  output logic                        done,
  output logic                        abort,
  output logic                        err
);
  localparam int CMD_CW = $clog2(CMD_WORDS + 1);
  localparam int CNT_W = (LEN_W > CMD_CW) ? LEN_W : CMD_CW;
  localparam int BIT_W = $clog2(WORD_W);
  localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(WORD_W - 1);
  typedef enum logic [2:0] {S_IDLE, S_CMD, S_WAIT, S_RX, S_TX} state_t;
  state_t r_state, w_state_nx;
  logic [2:0] r_sclk_s, r_cs_s;
  logic [1:0] r_mosi_s, r_mode;
  logic [BIT_W-1:0] r_bit;
  logic [CNT_W-1:0] r_wcnt;
  logic [LEN_W-1:0] r_len;
  logic [WORD_W-1:0] r_sh, r_tx, r_rx_data;
  logic [CMD_WORDS*WORD_W-1:0] r_cmd;
  logic r_load, r_miso, r_cmd_valid, r_rx_valid, r_tx_ready, r_done, r_abort, r_err;
  logic w_rise, w_fall, w_lead, w_trail, w_sample, w_shift, w_cs_fall, w_cs_rise;
  logic w_word_done, w_last_cmd, w_last_word, w_data, w_fin, w_tx_entry, w_tx_next, w_load;
  logic [WORD_W-1:0] w_word, w_ld;

  assign w_rise = r_sclk_s[1] & ~r_sclk_s[2];
  assign w_fall = ~r_sclk_s[1] & r_sclk_s[2];
  assign w_lead = r_mode[1] ? w_fall : w_rise;
  assign w_trail = r_mode[1] ? w_rise : w_fall;
  assign w_sample = r_mode[0] ? w_trail : w_lead;
  assign w_shift = r_mode[0] ? w_lead : w_trail;
  assign w_cs_fall = ~r_cs_s[1] & r_cs_s[2];
  assign w_cs_rise = r_cs_s[1] & ~r_cs_s[2];
  assign w_word = {r_sh[WORD_W-2:0], r_mosi_s[1]};
  assign w_data = (r_state == S_RX) || (r_state == S_TX);
  assign w_word_done = w_sample && (r_bit == '0);
  assign w_last_cmd = r_wcnt == CNT_W'(CMD_WORDS - 1);
  assign w_last_word = r_wcnt == CNT_W'(r_len);
  assign w_fin = w_data && w_word_done && w_last_word;
  assign w_tx_entry = (r_state == S_WAIT) && start && op;
  assign w_tx_next = (r_state == S_TX) && w_shift && r_load;
  assign w_load = w_tx_entry || w_tx_next;
  assign w_ld = tx_valid ? tx_data : FILL;

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: w_state_nx = w_cs_fall ? S_CMD : S_IDLE;
      S_CMD: w_state_nx = (w_word_done && w_last_cmd) ? S_WAIT : S_CMD;
      S_WAIT: w_state_nx = start ? (op ? S_TX : S_RX) : S_WAIT;
      default: w_state_nx = w_fin ? S_IDLE : r_state;
    endcase
    if (r_state != S_IDLE && w_cs_rise) w_state_nx = S_IDLE;
  end

  // cs synchroniser resets low so a reset taken mid-frame cannot fabricate a cs fall
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_sclk_s <= '0;
      r_cs_s <= '0;
      r_mosi_s <= '0;
      r_state <= S_IDLE;
      r_mode <= '0;
      r_bit <= BIT_MAX;
      r_wcnt <= '0;
      r_len <= '0;
      r_sh <= '0;
      r_tx <= '0;
      r_rx_data <= '0;
      r_cmd <= '0;
      r_load <= 1'b0;
      r_miso <= 1'b0;
      r_cmd_valid <= 1'b0;
      r_rx_valid <= 1'b0;
      r_tx_ready <= 1'b0;
      r_done <= 1'b0;
      r_abort <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_sclk_s <= {r_sclk_s[1:0], sclk};
      r_cs_s <= {r_cs_s[1:0], cs_n};
      r_mosi_s <= {r_mosi_s[0], mosi};
      r_state <= w_state_nx;
      r_cmd_valid <= 1'b0;
      r_rx_valid <= 1'b0;
      r_tx_ready <= 1'b0;
      r_done <= 1'b0;
      r_abort <= 1'b0;
      r_err <= 1'b0;
      if (r_state == S_IDLE) begin
        if (w_cs_fall) begin
          r_mode <= mode;
          r_bit <= BIT_MAX;
          r_wcnt <= '0;
          r_load <= 1'b0;
          r_miso <= FILL[WORD_W-1];
        end
      end else if (w_cs_rise && !w_fin) begin
        r_abort <= 1'b1;
        r_miso <= 1'b0;
      end else begin
        if (w_sample && r_state != S_WAIT) begin
          r_sh <= w_word;
          r_bit <= (r_bit == '0) ? BIT_MAX : r_bit - 1'b1;
        end
        if (w_shift) r_miso <= (r_state == S_TX) ? r_tx[r_bit] : FILL[r_bit];
        if (w_word_done && r_state == S_CMD) begin
          for (int k = 0; k < CMD_WORDS; k++)
            if (int'(r_wcnt) == k) r_cmd[(CMD_WORDS-1-k)*WORD_W +: WORD_W] <= w_word;
          r_wcnt <= w_last_cmd ? '0 : r_wcnt + 1'b1;
          r_cmd_valid <= w_last_cmd;
        end
        if (w_word_done && w_data) begin
          r_wcnt <= w_last_word ? r_wcnt : r_wcnt + 1'b1;
          r_load <= (r_state == S_TX) && !w_last_word;
          r_done <= w_last_word;
        end
        if (w_word_done && r_state == S_RX) begin
          r_rx_data <= w_word;
          r_rx_valid <= 1'b1;
        end
        if (r_state == S_WAIT && start) begin
          r_len <= len;
          r_wcnt <= '0;
        end
        // under CPHA=1 the first leading edge presents the MSB, so entry only stages the word
        if (w_load) begin
          r_tx <= w_ld;
          r_tx_ready <= tx_valid;
          r_load <= 1'b0;
          if (w_tx_next || !r_mode[0]) r_miso <= w_ld[WORD_W-1];
        end
        r_err <= (r_state == S_WAIT && w_sample) || (w_load && !tx_valid);
        if (w_fin) r_miso <= 1'b0;
      end
    end

  assign miso = r_miso;
  assign cmd = r_cmd;
  assign cmd_valid = r_cmd_valid;
  assign rx_data = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign tx_ready = r_tx_ready;
  assign busy = r_state != S_IDLE;
  assign done = r_done;
  assign abort = r_abort;
  assign err = r_err;
endmodule

// File: tb/tb_spi_stream_slave.sv
`timescale 1ns/1ps
// tb_spi_stream_slave: table-driven SPI frames with an rx scoreboard plus abort, reset and WAIT-edge sequences
module tb_spi_stream_slave;
  localparam int H = 80;
  typedef struct {
    logic [1:0] mode;
    logic op;
    int len;
    logic [47:0] cmd;
    logic [0:3][7:0] d;
    logic drop;
    int exp_err;
    int exp_txr;
  } vec_t;

  logic clk = 0, rst_n = 0, sclk = 0, cs_n = 1, mosi = 0, start = 1, op = 0, tx_valid = 1, drop = 0;
  logic [1:0] mode = 0;
  logic [5:0] len = 0;
  logic [7:0] tx_data = 0;
  logic miso, cmd_valid, rx_valid, tx_ready, busy, done, abort, err;
  logic [47:0] cmd;
  logic [7:0] rx_data;
  logic [7:0] rxq[$];
  logic [7:0] src[65];
  int idx = 0, nchk = 0, npass = 0;
  int n_cmdv, n_rxv, n_txr, n_done, n_abort, n_err;

  spi_stream_slave dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .mode(mode), .cmd(cmd), .cmd_valid(cmd_valid), .start(start), .op(op), .len(len),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .done(done), .abort(abort), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic clear_counts();
    n_cmdv = 0; n_rxv = 0; n_txr = 0; n_done = 0; n_abort = 0; n_err = 0;
  endtask

  function automatic logic [7:0] word_of(input vec_t v, input int i);
    return (i < 4) ? v.d[i] : 8'(i * 37 + 5);
  endfunction

  initial forever begin
    @(negedge clk);
    if (cmd_valid) n_cmdv++;
    if (tx_ready) n_txr++;
    if (done) n_done++;
    if (abort) n_abort++;
    if (err) n_err++;
    if (rx_valid) begin
      n_rxv++;
      chk("rx_expected", rxq.size() > 0, 1);
      if (rxq.size() > 0) chk("rx_word", rx_data, rxq.pop_front());
    end
  end

  initial forever begin
    @(negedge clk);
    if (tx_ready) begin
      idx++;
      if (drop) tx_valid = 0;
    end
    if (err && !tx_valid) tx_valid = 1;
    tx_data = src[idx];
  end

  initial begin
    #800000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

  task automatic host_bits(input logic [7:0] w, input int n, output logic [7:0] rd);
    rd = '0;
    for (int b = 7; b > 7 - n; b--) begin
      if (!mode[0]) begin
        mosi = w[b]; #H; rd[b] = miso; sclk = ~mode[1]; #H; sclk = mode[1];
      end else begin
        sclk = ~mode[1]; mosi = w[b]; #H; rd[b] = miso; sclk = mode[1]; #H;
      end
    end
  endtask

  task automatic open_frame(input logic [1:0] m, input logic o, input int l, input logic [47:0] c, input logic st);
    logic [7:0] rd;
    mode = m; sclk = m[1]; op = o; len = 6'(l); start = st;
    clear_counts();
    #200 cs_n = 0;
    #200;
    for (int k = 0; k < 6; k++) host_bits(c[(5-k)*8 +: 8], 8, rd);
    #300;
    chk("cmd", cmd, c);
    chk("cmd_valid_n", n_cmdv, 1);
    chk("busy_frame", busy, 1);
  endtask

  task automatic close_frame();
    #300 cs_n = 1;
    #300;
  endtask

  task automatic run_frame(input vec_t v);
    logic [7:0] rd, w;
    int k = 0;
    drop = v.drop; idx = 0; tx_valid = 1;
    for (int i = 0; i <= v.len; i++)
      if (!(v.drop && i == 1)) begin src[k] = word_of(v, i); k++; end
    tx_data = src[0];
    open_frame(v.mode, v.op, v.len, v.cmd, 1'b1);
    for (int i = 0; i <= v.len; i++) begin
      w = word_of(v, i);
      if (!v.op) begin
        rxq.push_back(w);
        host_bits(w, 8, rd);
      end else begin
        host_bits(8'h00, 8, rd);
        chk("tx_word", rd, (v.drop && i == 1) ? 8'hFF : w);
      end
    end
    close_frame();
    chk("done_n", n_done, 1);
    chk("abort_n", n_abort, 0);
    chk("err_n", n_err, v.exp_err);
    chk("tx_ready_n", n_txr, v.exp_txr);
    chk("rx_valid_n", n_rxv, v.op ? 0 : v.len + 1);
    chk("busy_idle", busy, 0);
    chk("rxq_left", rxq.size(), 0);
  endtask

  initial begin
    vec_t vecs[7];
    logic [7:0] rd;
    vecs[0] = '{2'd0, 1'b0, 3,  48'h400000000095, {8'hA5, 8'h5A, 8'h00, 8'hFF}, 1'b0, 0, 0};
    vecs[1] = '{2'd3, 1'b1, 1,  48'h0123456789AB, {8'h3C, 8'hC3, 8'h00, 8'h00}, 1'b0, 0, 2};
    vecs[2] = '{2'd1, 1'b1, 2,  48'hDEADBEEF0102, {8'h11, 8'h22, 8'h33, 8'h00}, 1'b1, 1, 2};
    vecs[3] = '{2'd2, 1'b0, 0,  48'hA1B2C3D4E5F6, {8'h7E, 8'h00, 8'h00, 8'h00}, 1'b0, 0, 0};
    vecs[4] = '{2'd0, 1'b1, 3,  48'h5500AA55FF00, {8'h81, 8'h42, 8'h24, 8'h18}, 1'b0, 0, 4};
    vecs[5] = '{2'd1, 1'b0, 63, 48'hFEDCBA987654, {8'h01, 8'h80, 8'hC0, 8'h03}, 1'b0, 0, 0};
    vecs[6] = '{2'd2, 1'b1, 0,  48'h13579BDF2468, {8'hE7, 8'h00, 8'h00, 8'h00}, 1'b0, 0, 1};
    #25;
    chk("rst_miso", miso, 0);
    chk("rst_cmd", cmd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_pulses", {cmd_valid, rx_valid, tx_ready, done, abort, err}, 0);
    rst_n = 1;
    #100;
    for (int i = 0; i < 7; i++) run_frame(vecs[i]);
    idx = 0; drop = 0; tx_valid = 1;
    open_frame(2'd0, 1'b0, 7, 48'h0102030405F0, 1'b1);
    rxq.push_back(8'hA5);
    host_bits(8'hA5, 8, rd);
    host_bits(8'h3C, 5, rd);
    close_frame();
    chk("abrt_abort_n", n_abort, 1);
    chk("abrt_done_n", n_done, 0);
    chk("abrt_rx_valid_n", n_rxv, 1);
    chk("abrt_rxq_left", rxq.size(), 0);
    chk("abrt_busy", busy, 0);
    run_frame(vecs[0]);
    open_frame(2'd0, 1'b0, 0, 48'h0F1E2D3C4B5A, 1'b0);
    host_bits(8'h80, 1, rd);
    #300;
    chk("wait_err_n", n_err, 1);
    chk("wait_busy", busy, 1);
    close_frame();
    chk("wait_abort_n", n_abort, 1);
    chk("wait_rx_valid_n", n_rxv, 0);
    mode = 2'd0; sclk = 0; start = 1; op = 0;
    clear_counts();
    #200 cs_n = 0;
    #200;
    host_bits(8'h12, 8, rd);
    host_bits(8'h34, 8, rd);
    host_bits(8'hE0, 3, rd);
    chk("pre_rst_busy", busy, 1);
    rst_n = 0;
    #1;
    chk("mid_rst_cmd", cmd, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_miso", miso, 0);
    chk("mid_rst_rx_data", rx_data, 0);
    chk("mid_rst_pulses", {cmd_valid, rx_valid, tx_ready, done, abort, err}, 0);
    #50 rst_n = 1;
    #100 cs_n = 1;
    #200;
    run_frame(vecs[3]);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
